fetch_unit: RTL
===============

// Module: fetch_unit
// PURPOSE
//   Instruction-fetch initiator for mainmem. Drives the word address and read_write onto the
//   memory bus and captures each returned word with its PC into a small FIFO. Presents the
//   instruction downstream through a valid/ready handshake. Accepts PC redirects (branch/jump).
//   Sits between mainmem and the decode stage of the RV32I core.
// PARAMETERS
//   STARTING_ADDR  'h01000000  Reset PC; base of the mainmem window.
//   MEM_BYTES      'h0100000   Window size; legal fetch PCs are STARTING_ADDR .. STARTING_ADDR+MEM_BYTES-4.
//   FIFO_DEPTH     2           Entries in the {pc,insn} buffer. Power of 2, >=2.
// PORTS
//   clock           in   1   Single clock; all state changes on posedge.
//   reset           in   1   Synchronous, active-high.
//   mem_address     out  32  Equals fetch_pc combinationally; word aligned.
//   mem_data_in     out  32  Constant 0; this block never writes.
//   mem_read_write  out  1   Constant READ (0).
//   mem_data_out    in   32  Read data from mainmem; combinational in mem_address.
//   redirect_valid  in   1   Load redirect_pc this cycle.
//   redirect_pc     in   32  New fetch PC.
//   insn_valid      out  1   FIFO head holds a valid instruction.
//   insn_ready      in   1   Downstream accepts the head; pops the FIFO when insn_valid=1.
//   insn_pc         out  32  PC of the head entry.
//   insn            out  32  Instruction word of the head entry.
//   fetch_done      out  1   fetch_pc has passed the end of the window.
//   align_err       out  1   Misaligned redirect trapped. Present only with FETCH_ALIGN_CHECK_EN.
// BEHAVIOUR
//   Reset: fetch_pc=STARTING_ADDR; FIFO empty; state=FETCH.
//     Output values: insn_valid=0, insn_pc=0, insn=0, fetch_done=0, align_err=0.
//   FSM states FETCH, FULL, DONE, ERR.
//     FETCH: push allowed when count<FIFO_DEPTH, or when a pop occurs in the same cycle.
//       On push, {fetch_pc, mem_data_out} is written at the posedge and fetch_pc+=4.
//     FETCH->FULL: count reaches FIFO_DEPTH with no pop.
//     FULL->FETCH: the cycle after any pop.
//     FETCH->DONE: a push at fetch_pc == STARTING_ADDR+MEM_BYTES-4. fetch_pc then holds and
//       fetch_done=1. DONE issues no further pushes; the FIFO keeps draining.
//   Latency: word at mem_address is captured on the same edge. insn_valid rises one cycle
//     after the push edge. Sustained throughput is 1 insn/cycle while insn_ready=1.
//   Redirect (highest priority): FIFO flushed, any concurrent pop or push discarded,
//     fetch_pc<=redirect_pc&~3, state->FETCH, fetch_done cleared.
//     Next cycle: insn_valid=0. First redirected insn is valid 2 cycles after the redirect edge.
//     redirect_pc outside the window forces DONE immediately.
//   Pointers wrap modulo FIFO_DEPTH; count is separate, width $clog2(FIFO_DEPTH)+1.
//   Reset asserted mid-stream: discards FIFO contents and any pending redirect; same values as reset.
//   mem_address changes only after posedge, so mainmem read data is stable before the next edge.
//   PC arithmetic is 32-bit unsigned. Window check uses (fetch_pc-STARTING_ADDR) < MEM_BYTES.
// CONFIGURATION
//   FETCH_ALIGN_CHECK_EN defined:
//     redirect_valid with redirect_pc[1:0]!=0 -> flush FIFO, state=ERR, align_err=1.
//     No fetch in ERR; only reset exits ERR.
//   FETCH_ALIGN_CHECK_EN undefined:
//     No align_err port, no ERR state; redirect_pc[1:0] silently forced to 0.
// TESTING
//   1 Reset, insn_ready=1, mem word0='h00000093 -> cycle 2: insn_valid=1,
//     insn_pc='h01000000, insn='h00000093. Next cycles give pc +4 per cycle.
//   2 insn_ready=0 for 6 cycles -> exactly 2 entries buffered; mem_address holds 'h01000008.
//     Release ready -> 'h01000000, 'h01000004, 'h01000008 in order, no gaps or duplicates.
//   3 redirect_valid with redirect_pc='h01000040 while FIFO full and ready=1 ->
//     insn_valid=0 next cycle, then insn_pc='h01000040; no stale PC appears.
//   4 redirect_pc='h010FFFFC -> one insn at 'h010FFFFC, then fetch_done=1, no further valid.
//   5 redirect_pc='h01000042: with FETCH_ALIGN_CHECK_EN, align_err=1 and insn_valid stays 0.
//     Without it, next insn_pc='h01000040.
//   6 Reset asserted while 2 entries are buffered -> next cycle insn_valid=0,
//     mem_address='h01000000, mem_read_write=0 throughout.

Source files
------------

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch initiator with {pc,insn} buffer; optional misaligned-redirect trap via FETCH_ALIGN_CHECK_EN
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR = 32'h0100_0000,
  parameter logic [31:0] MEM_BYTES     = 32'h0010_0000,
  parameter int          FIFO_DEPTH    = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic [31:0] mem_data_in,
  output logic        mem_read_write,
  input  logic [31:0] mem_data_out,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [31:0] insn_pc,
  output logic [31:0] insn,
  output logic        fetch_done
`ifdef FETCH_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [31:0]   LAST_PC = STARTING_ADDR + MEM_BYTES - 32'd4;

  typedef enum logic [1:0] {
    ST_FETCH,
    ST_FULL,
    ST_DONE
`ifdef FETCH_ALIGN_CHECK_EN
    ,
    ST_ERR
`endif
  } state_t;

  state_t          state_q, state_d;
  logic [31:0]     fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [31:0]     pc_mem_q   [FIFO_DEPTH];
  logic [31:0]     pc_mem_d   [FIFO_DEPTH];
  logic [31:0]     insn_mem_q [FIFO_DEPTH];
  logic [31:0]     insn_mem_d [FIFO_DEPTH];

  logic            pop;
  logic            push;
  logic            redirect_take;
  logic [31:0]     redirect_target;
  logic [31:0]     redirect_offset;
  logic            redirect_in_window;

  // The bus only ever reads, at the current fetch PC
  assign mem_address    = fetch_pc_q;
  assign mem_data_in    = 32'h0000_0000;
  assign mem_read_write = 1'b0;

  // Head of the buffer; pc/insn read as zero whenever the buffer is empty
  assign insn_valid = (count_q != '0);
  assign insn_pc    = insn_valid ? pc_mem_q[rd_ptr_q]   : 32'h0000_0000;
  assign insn       = insn_valid ? insn_mem_q[rd_ptr_q] : 32'h0000_0000;
  assign fetch_done = (state_q == ST_DONE);

`ifdef FETCH_ALIGN_CHECK_EN
  assign align_err     = (state_q == ST_ERR);
  assign redirect_take = redirect_valid && (state_q != ST_ERR);
`else
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];
  assign redirect_take        = redirect_valid;
`endif

  // Redirect target is word aligned; unsigned offset check also rejects PCs below the window
  assign redirect_target    = {redirect_pc[31:2], 2'b00};
  assign redirect_offset    = redirect_target - STARTING_ADDR;
  assign redirect_in_window = (redirect_offset < MEM_BYTES);

  // Next-state: redirect overrides everything, otherwise push/pop the buffer and advance the FSM
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    count_d    = count_q;
    pc_mem_d   = pc_mem_q;
    insn_mem_d = insn_mem_q;

    pop  = insn_valid && insn_ready;
    push = (state_q == ST_FETCH) && ((count_q < DEPTH_C) || pop);

    if (redirect_take) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
`ifdef FETCH_ALIGN_CHECK_EN
      if (redirect_pc[1:0] != 2'b00) begin
        state_d = ST_ERR;
      end else begin
        fetch_pc_d = redirect_target;
        state_d    = redirect_in_window ? ST_FETCH : ST_DONE;
      end
`else
      fetch_pc_d = redirect_target;
      state_d    = redirect_in_window ? ST_FETCH : ST_DONE;
`endif
    end else begin
      if (push) begin
        pc_mem_d[wr_ptr_q]   = fetch_pc_q;
        insn_mem_d[wr_ptr_q] = mem_data_out;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase

      case (state_q)
        ST_FETCH: begin
          if (push) begin
            if (fetch_pc_q == LAST_PC) begin
              state_d = ST_DONE;
            end else begin
              fetch_pc_d = fetch_pc_q + 32'd4;
              if (!pop && (count_q == DEPTH_C - CW'(1))) begin
                state_d = ST_FULL;
              end
            end
          end
        end
        ST_FULL: begin
          if (pop) begin
            state_d = ST_FETCH;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  // Control registers with synchronous reset; reset also drops any same-cycle redirect
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= ST_FETCH;
      fetch_pc_q <= STARTING_ADDR;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
    end
  end

  // Buffer storage needs no reset: entries are only visible while count is nonzero
  always_ff @(posedge clock) begin
    pc_mem_q   <= pc_mem_d;
    insn_mem_q <= insn_mem_d;
  end

endmodule
